return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
- Hardware call/return address stack for the RAT CPU, directly upstream of the PC and its PC_MUX.
- On CALL it pushes the return address (PC_COUNT + 1).
- It continuously presents the top-of-stack on FROM_STACK, which the PC_MUX selects on RET (PC_MUX_SEL = 1).
- Control signals come from the control unit FSM.

Parameters:
- ADDR_WIDTH, 10, width of PC addresses (matches PC_COUNT / FROM_STACK).
- DEPTH, 32, number of stack entries; must be a power of two, ≥ 2.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous active-high reset.
- PUSH  input  1  push PC_COUNT+1 at next rising edge (CALL).
- POP  input  1  pop top entry at next rising edge (RET).
- CLR_ERR  input  1  synchronous clear of the OVERFLOW/UNDERFLOW sticky flags.
- PC_COUNT  input  ADDR_WIDTH  current PC value from the program counter.
- FROM_STACK  output  ADDR_WIDTH  current top-of-stack entry; feeds PC_MUX input 1.
- SP  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- EMPTY  output  1  SP == 0.
- FULL  output  1  SP == DEPTH.
- OVERFLOW  output  1  sticky: a push was attempted while FULL.
- UNDERFLOW  output  1  sticky: a pop was attempted while EMPTY.

Behaviour:
- Reset (async, RST=1): SP=0, OVERFLOW=0, UNDERFLOW=0, so EMPTY=1, FULL=0, FROM_STACK=0. Storage array is not cleared. Reset asserted mid-operation discards all entries immediately, with no clock edge needed.
- Storage: DEPTH x ADDR_WIDTH register array. Entry i is valid for i < SP.
- FROM_STACK is combinational from the registers: mem[SP-1] when SP>0, else 0. It updates in the same cycle SP changes, with no extra latency.
- Push value: PC_COUNT + 1, truncated to ADDR_WIDTH bits (10'h3FF pushes 10'h000).
- Action per rising edge, evaluated on {PUSH,POP} with state sampled before the edge:
  - 00: hold.
  - 10, not FULL: mem[SP] <= PC_COUNT+1; SP <= SP+1.
  - 10, FULL: no write; SP unchanged; OVERFLOW <= 1.
  - 01, not EMPTY: SP <= SP-1 (data not erased).
  - 01, EMPTY: SP stays 0; UNDERFLOW <= 1.
  - 11, not EMPTY: replace top: mem[SP-1] <= PC_COUNT+1; SP unchanged; no flag changes, including when FULL.
  - 11, EMPTY: behaves as push (SP -> 1); UNDERFLOW not set.
- RET timing contract: control asserts POP together with PC_LD=1, PC_MUX_SEL=1 in the same cycle. The PC loads the pre-edge FROM_STACK while SP decrements on the same edge.
- CALL timing contract: PUSH is asserted in the cycle PC_COUNT holds the CALL instruction address.
- CLR_ERR: at the edge, OVERFLOW and UNDERFLOW <= 0. If a new overflow/underflow occurs in the same cycle, the set wins.
- Flags never affect stack contents. EMPTY and FULL are pure decodes of SP.
- No X propagation: FROM_STACK never reads an unwritten entry, because SP gates the read.

Test Plan:
- Reset and empty: RST=1 for 1 cycle, then idle -> SP=0, EMPTY=1, FROM_STACK=10'h000. POP once -> UNDERFLOW=1, SP stays 0. CLR_ERR one cycle -> UNDERFLOW=0.
- Push/pop order: push with PC_COUNT=10'h00A, then 10'h01F, then 10'h3FF -> FROM_STACK 10'h00B, 10'h020, 10'h000 after each edge; SP=3. Three POPs -> FROM_STACK 10'h020, 10'h00B, 10'h000; EMPTY=1.
- Fill/overflow: 32 pushes with PC_COUNT=0..31 -> FULL=1, SP=32, FROM_STACK=10'd32. 33rd push with PC_COUNT=10'h100 -> SP=32, FROM_STACK still 10'd32, OVERFLOW=1.
- Simultaneous: push 10'h004 (top 10'h005), then PUSH=POP=1 with PC_COUNT=10'h050 -> SP unchanged at 1, FROM_STACK=10'h051. From EMPTY, PUSH=POP=1 with PC_COUNT=10'h007 -> SP=1, FROM_STACK=10'h008, UNDERFLOW=0.
- Integration with PC+PC_MUX: PC at 10'h010, CALL (PUSH) then jump to 10'h080 via FROM_IMMED. Later RET: POP with PC_LD=1, PC_MUX_SEL=1 -> PC_COUNT=10'h011 after the edge, SP back to 0.
- Async reset mid-stack: SP=5, assert RST between clock edges -> SP=0, FROM_STACK=0, EMPTY=1 immediately, before the next rising edge.

Source files
------------

// File: rtl/return_addr_stack.sv
// Hardware call/return address stack: pushes PC+1 on CALL and presents the
// top of stack combinationally for the PC mux to select on RET.
module return_addr_stack #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr_err,
  input  logic [ADDR_WIDTH-1:0]        pc_count,
  output logic [ADDR_WIDTH-1:0]        from_stack,
  output logic [$clog2(DEPTH):0]       sp,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      top_idx;
  logic [ADDR_WIDTH-1:0] push_val;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [SP_W-1:0]       sp_d;
  logic                  overflow_d;
  logic                  underflow_d;

  assign empty    = (sp == '0);
  assign full     = (sp == SP_W'(DEPTH));
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign push_val = pc_count + ADDR_WIDTH'(1);

  // The SP gate keeps unwritten entries from ever reaching the PC mux.
  assign from_stack = empty ? '0 : mem[top_idx];

  // Next-state decode on {push,pop}; a same-cycle flag set beats clr_err.
  always_comb begin
    wr_en       = 1'b0;
    wr_idx      = IDX_W'(sp);
    sp_d        = sp;
    overflow_d  = clr_err ? 1'b0 : overflow;
    underflow_d = clr_err ? 1'b0 : underflow;
    case ({push, pop})
      2'b10: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp + SP_W'(1);
        end
      end
      2'b01: begin
        if (empty) underflow_d = 1'b1;
        else       sp_d        = sp - SP_W'(1);
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          wr_idx = '0;
          sp_d   = SP_W'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

  // Storage is intentionally not reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_val;
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack, including a small
// PC register and PC mux to exercise the CALL/RET timing.
module tb_return_addr_stack;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic          clr_err;
  logic [AW-1:0] pc_count;
  logic [AW-1:0] from_stack;
  logic [5:0]    sp;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  // PC + PC_MUX model used for the integration sequence
  logic          use_pc;
  logic [AW-1:0] pc_drv;
  logic [AW-1:0] pc_q;
  logic          pc_ld;
  logic          pc_inc;
  logic          pc_mux_sel;
  logic [AW-1:0] from_immed;

  int errors;
  int checks;

  return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .clr_err    (clr_err),
    .pc_count   (pc_count),
    .from_stack (from_stack),
    .sp         (sp),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc_q <= '0;
    else if (pc_ld)  pc_q <= pc_mux_sel ? from_stack : from_immed;
    else if (pc_inc) pc_q <= pc_q + AW'(1);
  end

  assign pc_count = use_pc ? pc_q : pc_drv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    use_pc = 1'b0; pc_drv = '0; pc_ld = 1'b0; pc_inc = 1'b0;
    pc_mux_sel = 1'b0; from_immed = '0;

    // Reset and empty behaviour
    step();
    rst = 1'b0;
    step();
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_top", 32'(from_stack), 32'h000);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    pop = 1'b1; step(); pop = 1'b0;
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_sp", 32'(sp), 32'd0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("unf_clr", 32'(underflow), 32'd0);

    // Push/pop ordering with wraparound of PC+1
    push = 1'b1;
    pc_drv = 10'h00A; step(); chk("push1_top", 32'(from_stack), 32'h00B);
    pc_drv = 10'h01F; step(); chk("push2_top", 32'(from_stack), 32'h020);
    pc_drv = 10'h3FF; step(); chk("push3_top", 32'(from_stack), 32'h000);
    chk("push3_sp", 32'(sp), 32'd3);
    push = 1'b0; pop = 1'b1;
    step(); chk("pop1_top", 32'(from_stack), 32'h020);
    step(); chk("pop2_top", 32'(from_stack), 32'h00B);
    step(); chk("pop3_top", 32'(from_stack), 32'h000);
    chk("pop3_empty", 32'(empty), 32'd1);
    pop = 1'b0;

    // Fill and overflow
    push = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pc_drv = AW'(i);
      step();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_sp", 32'(sp), 32'd32);
    chk("fill_top", 32'(from_stack), 32'd32);
    pc_drv = 10'h100; step();
    chk("ovf_sp", 32'(sp), 32'd32);
    chk("ovf_top", 32'(from_stack), 32'd32);
    chk("ovf_flag", 32'(overflow), 32'd1);
    pop = 1'b1; pc_drv = 10'h200; step();
    chk("full_repl_sp", 32'(sp), 32'd32);
    chk("full_repl_top", 32'(from_stack), 32'h201);
    pop = 1'b0; clr_err = 1'b1; step();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    push = 1'b0; step(); clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    pop = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      step();
      chk("drain_sp", 32'(sp), 32'(32 - n));
      chk("drain_top", 32'(from_stack), 32'(32 - n));
    end
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_unf", 32'(underflow), 32'd0);

    // Simultaneous push and pop
    push = 1'b1; pc_drv = 10'h004; step();
    chk("sim_pre_top", 32'(from_stack), 32'h005);
    pop = 1'b1; pc_drv = 10'h050; step();
    chk("sim_sp", 32'(sp), 32'd1);
    chk("sim_top", 32'(from_stack), 32'h051);
    push = 1'b0; step();
    chk("sim_pop_empty", 32'(empty), 32'd1);
    push = 1'b1; pc_drv = 10'h007; step();
    chk("sim_empty_sp", 32'(sp), 32'd1);
    chk("sim_empty_top", 32'(from_stack), 32'h008);
    chk("sim_empty_unf", 32'(underflow), 32'd0);
    push = 1'b0; step();
    chk("sim_done_empty", 32'(empty), 32'd1);
    pop = 1'b0;

    // CALL/RET through the PC and PC mux
    use_pc = 1'b1;
    pc_ld = 1'b1; pc_mux_sel = 1'b0; from_immed = 10'h010; step();
    chk("int_pc_init", 32'(pc_q), 32'h010);
    push = 1'b1; from_immed = 10'h080; step();
    push = 1'b0; pc_ld = 1'b0;
    chk("int_call_pc", 32'(pc_q), 32'h080);
    chk("int_call_top", 32'(from_stack), 32'h011);
    chk("int_call_sp", 32'(sp), 32'd1);
    pc_inc = 1'b1; step(); step(); pc_inc = 1'b0;
    chk("int_body_pc", 32'(pc_q), 32'h082);
    pop = 1'b1; pc_ld = 1'b1; pc_mux_sel = 1'b1; step();
    pop = 1'b0; pc_ld = 1'b0; pc_mux_sel = 1'b0;
    chk("int_ret_pc", 32'(pc_q), 32'h011);
    chk("int_ret_sp", 32'(sp), 32'd0);
    use_pc = 1'b0;

    // Asynchronous reset between clock edges
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_drv = AW'(10'h040 + i);
      step();
    end
    push = 1'b0;
    chk("async_pre_sp", 32'(sp), 32'd5);
    chk("async_pre_top", 32'(from_stack), 32'h045);
    #2 rst = 1'b1;
    #1;
    chk("async_sp", 32'(sp), 32'd0);
    chk("async_top", 32'(from_stack), 32'h000);
    chk("async_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    step();
    chk("async_post_sp", 32'(sp), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
